// File: rtl/tinyml_hw_accel_pixel_packer_pkg.sv
// Shared helpers for the pixel packer: width calculations used by the top level and its word FIFO.
package tinyml_hw_accel_pixel_packer_pkg;

   // Ceiling log2 that never returns 0, so a degenerate range still gets a 1-bit register.
   function automatic int clog2_min1(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int pixels_per_word(input int out_width, input int pixel_width);
      return out_width / pixel_width;
   endfunction

   function automatic int frame_pixels(input int frame_width, input int frame_height);
      return frame_width * frame_height;
   endfunction

endpackage

// File: rtl/tinyml_hw_accel_sync_fifo.sv
// Single-clock show-ahead FIFO; the head entry is visible on dout whenever the FIFO is not empty.
module tinyml_hw_accel_sync_fifo
   import tinyml_hw_accel_pixel_packer_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         sw_clear,
   input  logic                         push,
   input  logic [WIDTH-1:0]             din,
   input  logic                         pop,
   output logic [WIDTH-1:0]             dout,
   output logic                         full,
   output logic                         empty,
   output logic [clog2_min1(DEPTH):0]   count
);

   localparam int AW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d;
   logic             wr_en;
   logic             rd_en;

   assign empty = (count_q == '0);
   assign full  = (count_q == (AW+1)'(DEPTH));
   assign count = count_q;
   // Gate the head so an empty FIFO presents zeros rather than a stale entry.
   assign dout  = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      rd_en    = pop & ~empty;
      wr_en    = push & (~full | rd_en);
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (wr_en) begin
         mem_d[wr_ptr_q] = din;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (rd_en) begin
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
      if (sw_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/tinyml_hw_accel_pixel_packer.sv
// Packs a PPC-wide pixel stream into OUT_DATA_WIDTH words, tags the frame-final word and queues words
// for a valid/ready consumer.
module tinyml_hw_accel_pixel_packer
   import tinyml_hw_accel_pixel_packer_pkg::*;
#(
   parameter int PIXEL_DATA_WIDTH = 8,
   parameter int PPC              = 1,
   parameter int OUT_DATA_WIDTH   = 32,
   parameter int FRAME_WIDTH      = 3,
   parameter int FRAME_HEIGHT     = 3,
   parameter int FIFO_DEPTH       = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            sw_clear,
   input  logic [PPC*PIXEL_DATA_WIDTH-1:0] in_pixel_data,
   input  logic                            in_pixel_data_valid,
   output logic [OUT_DATA_WIDTH-1:0]       out_data,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic                            out_last,
   output logic                            overflow
);

   localparam int PPW       = pixels_per_word(OUT_DATA_WIDTH, PIXEL_DATA_WIDTH);
   localparam int FRM_PIX   = frame_pixels(FRAME_WIDTH, FRAME_HEIGHT);
   localparam int CNT_W     = clog2_min1(FRM_PIX);
   localparam int LANE_W    = clog2_min1(PPW + 1);
   localparam int FIFO_AW   = clog2_min1(FIFO_DEPTH);
   localparam int ENTRY_W   = OUT_DATA_WIDTH + 1;

   logic [CNT_W-1:0]          pix_cnt_q, pix_cnt_d;
   logic [LANE_W-1:0]         lane_q, lane_d;
   logic [OUT_DATA_WIDTH-1:0] acc_q, acc_d;
   logic                      cw_vld_q, cw_vld_d;
   logic [ENTRY_W-1:0]        cw_data_q, cw_data_d;
   logic                      push_vld_q, push_vld_d;
   logic [ENTRY_W-1:0]        push_data_q, push_data_d;
   logic                      overflow_q, overflow_d;

   logic [OUT_DATA_WIDTH-1:0] acc_new;
   logic [CNT_W:0]            pix_sum;
   logic [LANE_W-1:0]         lane_sum;
   logic                      frame_end;

   logic [ENTRY_W-1:0]        fifo_dout;
   logic                      fifo_full;
   logic                      fifo_empty;
   logic [FIFO_AW:0]          fifo_count;
   logic                      fifo_pop;

   assign fifo_pop  = out_ready & ~fifo_empty;
   assign out_valid = (fifo_count != '0);
   assign out_data  = fifo_dout[OUT_DATA_WIDTH-1:0];
   assign out_last  = fifo_dout[OUT_DATA_WIDTH];
   assign overflow  = overflow_q;

   always_comb begin
      pix_cnt_d   = pix_cnt_q;
      lane_d      = lane_q;
      acc_d       = acc_q;
      cw_vld_d    = 1'b0;
      cw_data_d   = cw_data_q;
      push_vld_d  = cw_vld_q;
      push_data_d = cw_data_q;
      overflow_d  = overflow_q | (push_vld_q & fifo_full & ~fifo_pop);
      acc_new     = acc_q;
      pix_sum     = {1'b0, pix_cnt_q} + (CNT_W+1)'(PPC);
      lane_sum    = lane_q + LANE_W'(PPC);
      frame_end   = (pix_sum == (CNT_W+1)'(FRM_PIX));

      if (in_pixel_data_valid) begin
         for (int p = 0; p < PPC; p++) begin
            acc_new[(int'(lane_q) + p) * PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH] =
               in_pixel_data[p * PIXEL_DATA_WIDTH +: PIXEL_DATA_WIDTH];
         end
         // A frame-final beat flushes a partial word; lanes not yet written stay zero from the clear.
         if ((lane_sum == LANE_W'(PPW)) || frame_end) begin
            cw_vld_d  = 1'b1;
            cw_data_d = {frame_end, acc_new};
            acc_d     = '0;
            lane_d    = '0;
         end else begin
            acc_d  = acc_new;
            lane_d = lane_sum;
         end
         pix_cnt_d = frame_end ? '0 : pix_sum[CNT_W-1:0];
      end

      if (sw_clear) begin
         pix_cnt_d   = '0;
         lane_d      = '0;
         acc_d       = '0;
         cw_vld_d    = 1'b0;
         cw_data_d   = '0;
         push_vld_d  = 1'b0;
         push_data_d = '0;
         overflow_d  = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_cnt_q   <= '0;
         lane_q      <= '0;
         acc_q       <= '0;
         cw_vld_q    <= 1'b0;
         cw_data_q   <= '0;
         push_vld_q  <= 1'b0;
         push_data_q <= '0;
         overflow_q  <= 1'b0;
      end else begin
         pix_cnt_q   <= pix_cnt_d;
         lane_q      <= lane_d;
         acc_q       <= acc_d;
         cw_vld_q    <= cw_vld_d;
         cw_data_q   <= cw_data_d;
         push_vld_q  <= push_vld_d;
         push_data_q <= push_data_d;
         overflow_q  <= overflow_d;
      end
   end

   tinyml_hw_accel_sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .sw_clear (sw_clear),
      .push     (push_vld_q),
      .din      (push_data_q),
      .pop      (fifo_pop),
      .dout     (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

endmodule
